sad_window_fetch_ctrl: RTL and testbench

Multi-cycle sequencer that gathers the sixteen 32-bit operands (words A..P, a 4x4 pixel window) of a SAD instruction from data memory. It walks 4 rows x 4 words with a req/ack memory handshake and holds the assembled window. It stalls the pipeline while fetching, then presents the complete window to the MEM/WB stage register on a one-cycle Done. It sits beside the MEM stage, between the data-memory port and the SAD operand inputs of that register.

---
 rtl/sad_window_fetch_ctrl_if.sv | 37 +++
 rtl/sad_window_fetch_ctrl.sv | 110 +++++++++++
 tb/tb_sad_window_fetch_ctrl.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/sad_window_fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : sad_window_fetch_ctrl_if
//  Description : Pipeline-side and data-memory-side signal bundle of the SAD
//                window fetch sequencer. The master modport is the
//                sequencer; the slave modport is its environment (pipeline
//                control plus data memory).
//  Revision    : 1.0  initial release
// ============================================================================
interface sad_window_fetch_ctrl_if;
    // pipeline request side
    logic         Start;
    logic [31:0]  Base;
    logic [15:0]  Stride;
    logic         Flush;
    // data-memory read port
    logic         MemReq;
    logic [31:0]  MemAddr;
    logic         MemAck;
    logic [31:0]  MemReadData;
    // pipeline status / MEM-WB operand side
    logic         Stall;
    logic         Busy;
    logic         Done;
    logic [511:0] Window;

    modport master (
        input  Start, Base, Stride, Flush, MemAck, MemReadData,
        output MemReq, MemAddr, Stall, Busy, Done, Window
    );

    modport slave (
        output Start, Base, Stride, Flush, MemAck, MemReadData,
        input  MemReq, MemAddr, Stall, Busy, Done, Window
    );
endinterface
`default_nettype wire

// File: rtl/sad_window_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sad_window_fetch_ctrl
//  Description : Gathers the 4x4 window of 32-bit operands for a SAD
//                instruction through a req/ack data-memory port, stalls the
//                pipeline while fetching and presents the assembled window
//                with a one-cycle Done pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module sad_window_fetch_ctrl (
    input  logic                     Clk,
    input  logic                     Reset,
    sad_window_fetch_ctrl_if.master  bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]   state;
    logic [1:0]   row;
    logic [1:0]   col;
    logic [31:0]  row_base;
    logic [31:0]  addr;
    logic [15:0]  stride;
    logic [511:0] window;

    logic         idle_or_done;
    logic         start_ok;
    logic         ack_ok;
    logic         last_col;
    logic         last_word;
    logic [31:0]  base_aligned;
    logic [15:0]  stride_aligned;
    logic [31:0]  next_row_base;
    logic [3:0]   word_idx;

    assign idle_or_done   = (state == S_IDLE) || (state == S_DONE);
    // Flush outranks both a new Start and an arriving ack
    assign start_ok       = idle_or_done & bus.Start & ~bus.Flush;
    assign ack_ok         = (state == S_FETCH) & bus.MemAck & ~bus.Flush;
    assign last_col       = (col == 2'd3);
    assign last_word      = last_col && (row == 2'd3);
    assign base_aligned   = bus.Base & 32'hFFFF_FFFC;
    assign stride_aligned = bus.Stride & 16'hFFFC;
    assign next_row_base  = row_base + {16'd0, stride};
    assign word_idx       = {row, col};

    // Sequencer state: IDLE -> FETCH (16 accepted acks) -> DONE, Flush aborts
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= S_IDLE;
        end else if (bus.Flush) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_DONE: state <= bus.Start ? S_FETCH : S_IDLE;
                S_FETCH:        if (bus.MemAck && last_word) state <= S_DONE;
                default:        state <= S_IDLE;
            endcase
        end
    end

    // Address walk: addr always equals row_base + col*4, kept in its own
    // register so MemAddr has no combinational path from MemAck
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            row      <= 2'd0;
            col      <= 2'd0;
            row_base <= 32'd0;
            addr     <= 32'd0;
            stride   <= 16'd0;
        end else if (start_ok) begin
            row      <= 2'd0;
            col      <= 2'd0;
            row_base <= base_aligned;
            addr     <= base_aligned;
            stride   <= stride_aligned;
        end else if (ack_ok) begin
            if (last_col) begin
                col      <= 2'd0;
                row      <= row + 2'd1;
                row_base <= next_row_base;
                addr     <= next_row_base;
            end else begin
                col      <= col + 2'd1;
                addr     <= addr + 32'd4;
            end
        end
    end

    // Window storage: only accepted acks write; a new fetch does not clear it
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            window <= '0;
        end else if (ack_ok) begin
            window[{word_idx, 5'd0} +: 32] <= bus.MemReadData;
        end
    end

    assign bus.MemReq  = (state == S_FETCH);
    assign bus.MemAddr = addr;
    assign bus.Busy    = (state == S_FETCH);
    assign bus.Done    = (state == S_DONE);
    // Stall already in the Start cycle so the issuing stage freezes at once
    assign bus.Stall   = (state == S_FETCH) | start_ok;
    assign bus.Window  = window;

endmodule
`default_nettype wire

// File: tb/tb_sad_window_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sad_window_fetch_ctrl
//  Description : Directed self-checking bench for the SAD window fetch
//                sequencer. Memory returns addr ^ DATA_KEY for every read.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sad_window_fetch_ctrl;

    localparam logic [31:0] DATA_KEY = 32'hA5A5_5A5A;

    logic Clk = 1'b0;
    logic Reset;

    always #5 Clk = ~Clk;

    sad_window_fetch_ctrl_if bus ();

    sad_window_fetch_ctrl dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_value(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_addr(input logic [31:0] base, input logic [15:0] stride, input int k);
        logic [31:0] b;
        logic [31:0] s;
        b = base & 32'hFFFF_FFFC;
        s = {16'd0, stride & 16'hFFFC};
        return b + s * 32'(k / 4) + 32'(k % 4) * 32'd4;
    endfunction

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ DATA_KEY;
    endfunction

    function automatic logic [511:0] exp_window(input logic [31:0] base, input logic [15:0] stride);
        logic [511:0] w;
        for (int k = 0; k < 16; k++)
            w[k*32 +: 32] = mem_data(exp_addr(base, stride, k));
        return w;
    endfunction

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_window(input string name, input logic [511:0] exp);
        for (int k = 0; k < 16; k++)
            check_value($sformatf("%s_word%0d", name, k), bus.Window[k*32 +: 32], exp[k*32 +: 32]);
    endtask

    // Issues Start in the current cycle (IDLE or DONE), serves the reads with
    // wait_n cycles per word and returns during the Done cycle.
    task automatic run_fetch(input string name, input logic [31:0] base, input logic [15:0] stride,
                             input int wait_n, input int exp_cycles);
        int   cycles;
        int   idx;
        int   h;
        logic acked;
        bus.Base   = base;
        bus.Stride = stride;
        bus.Start  = 1'b1;
        #1;
        check_value({name, "_stall_start"}, bus.Stall, 1'b1);
        step();
        bus.Start  = 1'b0;
        bus.Base   = 32'hDEAD_BEEF;
        bus.Stride = 16'hFFFF;
        cycles = 0;
        idx    = 0;
        h      = 0;
        while (cycles < 400 && !bus.Done) begin
            check_value($sformatf("%s_req%0d", name, idx), bus.MemReq, 1'b1);
            check_value($sformatf("%s_stall%0d", name, idx), bus.Stall, 1'b1);
            check_value($sformatf("%s_addr%0d", name, idx), bus.MemAddr, exp_addr(base, stride, idx));
            bus.MemReadData = mem_data(exp_addr(base, stride, idx));
            bus.MemAck      = (h == wait_n - 1);
            acked           = bus.MemAck;
            step();
            cycles++;
            if (acked) begin
                idx++;
                h = 0;
            end else begin
                h++;
            end
        end
        bus.MemAck = 1'b0;
        #1;
        check_value({name, "_done"}, bus.Done, 1'b1);
        check_value({name, "_cycles"}, cycles, exp_cycles);
        check_value({name, "_req_in_done"}, bus.MemReq, 1'b0);
        check_value({name, "_busy_in_done"}, bus.Busy, 1'b0);
        check_value({name, "_stall_in_done"}, bus.Stall, 1'b0);
        check_window(name, exp_window(base, stride));
    endtask

    initial begin
        logic [511:0] prior;
        logic [511:0] expw;

        Reset           = 1'b0;
        bus.Start       = 1'b0;
        bus.Base        = 32'd0;
        bus.Stride      = 16'd0;
        bus.Flush       = 1'b0;
        bus.MemAck      = 1'b0;
        bus.MemReadData = 32'd0;

        // reset state
        #3;
        check_value("rst_req", bus.MemReq, 1'b0);
        check_value("rst_addr", bus.MemAddr, 32'd0);
        check_value("rst_busy", bus.Busy, 1'b0);
        check_value("rst_done", bus.Done, 1'b0);
        check_value("rst_stall", bus.Stall, 1'b0);
        check_value("rst_window", bus.Window, 512'd0);
        bus.Start = 1'b1;
        #1;
        check_value("rst_stall_start", bus.Stall, 1'b1);
        bus.Start = 1'b0;
        #8;
        Reset = 1'b1;
        step();
        check_value("rst_idle_busy", bus.Busy, 1'b0);

        // zero-wait fetch
        run_fetch("zw", 32'h0000_1000, 16'h0040, 1, 16);
        step();
        check_value("zw_done_pulse", bus.Done, 1'b0);
        check_value("zw_idle_busy", bus.Busy, 1'b0);
        check_value("zw_idle_stall", bus.Stall, 1'b0);

        // ack outside FETCH is ignored
        bus.MemAck      = 1'b1;
        bus.MemReadData = 32'h1234_5678;
        step();
        bus.MemAck = 1'b0;
        check_value("idle_ack_busy", bus.Busy, 1'b0);
        check_value("idle_ack_window", bus.Window, exp_window(32'h0000_1000, 16'h0040));

        // three cycles per word, then back-to-back misaligned fetch
        run_fetch("w3", 32'h0000_1000, 16'h0040, 3, 48);
        run_fetch("b2b", 32'h0000_2001, 16'h0040, 1, 16);
        step();
        check_value("b2b_idle_done", bus.Done, 1'b0);

        // address wrap-around
        run_fetch("wrap", 32'hFFFF_FFF8, 16'h0010, 1, 16);
        step();

        // Flush together with the seventh ack
        prior = exp_window(32'hFFFF_FFF8, 16'h0010);
        bus.Base   = 32'h0000_3000;
        bus.Stride = 16'h0020;
        bus.Start  = 1'b1;
        step();
        bus.Start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            bus.MemAck      = 1'b1;
            bus.MemReadData = mem_data(exp_addr(32'h0000_3000, 16'h0020, k));
            step();
        end
        check_value("fl_addr6", bus.MemAddr, exp_addr(32'h0000_3000, 16'h0020, 6));
        bus.Flush       = 1'b1;
        bus.MemReadData = mem_data(exp_addr(32'h0000_3000, 16'h0020, 6));
        step();
        bus.Flush  = 1'b0;
        bus.MemAck = 1'b0;
        #1;
        check_value("fl_busy", bus.Busy, 1'b0);
        check_value("fl_req", bus.MemReq, 1'b0);
        check_value("fl_done", bus.Done, 1'b0);
        check_value("fl_stall", bus.Stall, 1'b0);
        expw = prior;
        for (int k = 0; k < 6; k++)
            expw[k*32 +: 32] = mem_data(exp_addr(32'h0000_3000, 16'h0020, k));
        check_window("fl", expw);
        step();
        check_value("fl_no_done_later", bus.Done, 1'b0);

        // async reset in the middle of a fetch (word 9 outstanding)
        bus.Base   = 32'h0000_1000;
        bus.Stride = 16'h0040;
        bus.Start  = 1'b1;
        step();
        bus.Start = 1'b0;
        for (int k = 0; k < 9; k++) begin
            bus.MemAck      = 1'b1;
            bus.MemReadData = mem_data(exp_addr(32'h0000_1000, 16'h0040, k));
            step();
        end
        bus.MemAck = 1'b0;
        check_value("ar_addr9", bus.MemAddr, exp_addr(32'h0000_1000, 16'h0040, 9));
        check_value("ar_req_before", bus.MemReq, 1'b1);
        #2;
        Reset = 1'b0;
        #1;
        check_value("ar_req", bus.MemReq, 1'b0);
        check_value("ar_busy", bus.Busy, 1'b0);
        check_value("ar_window", bus.Window, 512'd0);
        check_value("ar_addr", bus.MemAddr, 32'd0);
        check_value("ar_stall", bus.Stall, 1'b0);
        #1;
        Reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check_value($sformatf("ar_idle_busy%0d", k), bus.Busy, 1'b0);
            check_value($sformatf("ar_idle_req%0d", k), bus.MemReq, 1'b0);
        end
        check_value("ar_idle_window", bus.Window, 512'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
